// File: rtl/seq_pkg.sv
// ============================================================================
// Module   : seq_pkg
// Brief    : Shared constants for the multi-cycle instruction sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t C_ST_FETCH  = 3'd0;
    localparam state_t C_ST_DECODE = 3'd1;
    localparam state_t C_ST_EXEC   = 3'd2;
    localparam state_t C_ST_MEM    = 3'd3;
    localparam state_t C_ST_WB     = 3'd4;
    localparam state_t C_ST_HALT   = 3'd5;

    // Bit positions inside the one-hot class code
    localparam int C_CLS_JAL    = 0;
    localparam int C_CLS_JALR   = 1;
    localparam int C_CLS_AUIPC  = 2;
    localparam int C_CLS_LUI    = 3;
    localparam int C_CLS_BRANCH = 4;
    localparam int C_CLS_RALU   = 5;
    localparam int C_CLS_STORE  = 6;
    localparam int C_CLS_IALU   = 7;
    localparam int C_CLS_LOAD   = 8;
    localparam int C_CLS_SYSTEM = 9;
    localparam int C_CLS_FP     = 10;

    localparam logic [2:0] C_F3_BEQ  = 3'b000;
    localparam logic [2:0] C_F3_BNE  = 3'b001;
    localparam logic [2:0] C_F3_BLT  = 3'b100;
    localparam logic [2:0] C_F3_BGE  = 3'b101;
    localparam logic [2:0] C_F3_BLTU = 3'b110;
    localparam logic [2:0] C_F3_BGEU = 3'b111;
    localparam logic [2:0] C_F3_SRX  = 3'b101;

endpackage

`default_nettype wire

// File: rtl/insn_sequencer_mc_branch_cond.sv
// ============================================================================
// Module   : branch_cond
// Brief    : Branch-taken decision from funct3 and the ALU compare flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module branch_cond
    import seq_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       eq,
    input  logic       ls,
    input  logic       lu,
    output logic       taken,
    output logic       bad_funct3
);

    always_comb begin
        taken      = 1'b0;
        bad_funct3 = 1'b0;
        case (funct3)
            C_F3_BEQ:  taken = eq;
            C_F3_BNE:  taken = ~eq;
            C_F3_BLT:  taken = ls;
            C_F3_BGE:  taken = ~ls;
            C_F3_BLTU: taken = lu;
            C_F3_BGEU: taken = ~lu;
            default:   bad_funct3 = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/insn_sequencer_mc.sv
// ============================================================================
// Module   : insn_sequencer_mc
// Brief    : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with registered
//            enables, memory/FPU handshakes, bus timeout and retire counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module insn_sequencer_mc
    import seq_pkg::*;
#(
    parameter int N_CLASS     = 11,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_CLASS-1:0] code,
    input  logic [31:0]        insn,
    input  logic               EQ,
    input  logic               LS,
    input  logic               LU,
    input  logic               mem_ready,
    input  logic               fpu_done,
    output logic               mem_req,
    output logic               mem_we,
    output logic               addr_sel,
    output logic               ir_we,
    output logic               pc_we,
    output logic               pc_next_sel,
    output logic               pc_alu_sel,
    output logic               sub_sra,
    output logic               rd_we,
    output logic               frd_we,
    output logic               fpu_start,
    output logic               halted,
    output logic               illegal,
    output logic               bus_err,
    output logic [CNT_W-1:0]   instret
);

    // Counter only needs to hold MEM_TIMEOUT-1; the limit is detected one step early
    localparam int TO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] C_TO_LIMIT = TO_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next;
    logic [TO_W-1:0]    r_to_cnt;
    logic               r_fpu_started;
    logic               r_halted;
    logic               r_illegal;
    logic               r_bus_err;
    logic [CNT_W-1:0]   r_instret;

    logic w_taken;
    logic w_bad_f3;
    logic w_onehot;
    logic w_timeout;
    logic w_sub;
    logic w_retire;
    logic w_set_halt;
    logic w_set_ill;
    logic w_set_berr;

    logic w_jal, w_jalr, w_auipc, w_branch, w_ralu, w_store, w_ialu, w_load, w_sys, w_fp;

    assign w_jal    = code[C_CLS_JAL];
    assign w_jalr   = code[C_CLS_JALR];
    assign w_auipc  = code[C_CLS_AUIPC];
    assign w_branch = code[C_CLS_BRANCH];
    assign w_ralu   = code[C_CLS_RALU];
    assign w_store  = code[C_CLS_STORE];
    assign w_ialu   = code[C_CLS_IALU];
    assign w_load   = code[C_CLS_LOAD];
    assign w_sys    = code[C_CLS_SYSTEM];
    assign w_fp     = code[C_CLS_FP];

    assign w_onehot  = (code != '0) && ((code & (code - 1'b1)) == '0);
    assign w_timeout = (MEM_TIMEOUT != 0) && !mem_ready && (r_to_cnt == C_TO_LIMIT);
    assign w_sub     = (w_ralu & insn[30])
                     | (w_ialu & insn[30] & (insn[14:12] == C_F3_SRX))
                     | w_branch;

    branch_cond u_branch_cond (
        .funct3     (insn[14:12]),
        .eq         (EQ),
        .ls         (LS),
        .lu         (LU),
        .taken      (w_taken),
        .bad_funct3 (w_bad_f3)
    );

    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        w_set_halt  = 1'b0;
        w_set_ill   = 1'b0;
        w_set_berr  = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_next_sel = 1'b0;
        pc_alu_sel  = 1'b0;
        sub_sra     = 1'b0;
        rd_we       = 1'b0;
        frd_we      = 1'b0;
        fpu_start   = 1'b0;

        case (r_state)
            C_ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    w_next = C_ST_DECODE;
                end else if (w_timeout) begin
                    w_set_berr = 1'b1;
                    w_next     = C_ST_HALT;
                end
            end
            C_ST_DECODE: begin
                if (!w_onehot) begin
                    w_set_ill = 1'b1;
                    w_next    = C_ST_HALT;
                end else if (w_sys) begin
                    w_set_halt = 1'b1;
                    w_next     = C_ST_HALT;
                end else begin
                    w_next = C_ST_EXEC;
                end
            end
            C_ST_EXEC: begin
                pc_alu_sel = w_jal | w_auipc;
                sub_sra    = w_sub;
                if (w_branch) begin
                    pc_alu_sel = 1'b1;
                    if (w_bad_f3) begin
                        w_set_ill = 1'b1;
                        w_next    = C_ST_HALT;
                    end else begin
                        pc_we       = 1'b1;
                        pc_next_sel = w_taken;
                        w_retire    = 1'b1;
                        w_next      = C_ST_FETCH;
                    end
                end else if (w_load || w_store) begin
                    w_next = C_ST_MEM;
                end else if (w_fp) begin
                    fpu_start = ~r_fpu_started;
                    if (fpu_done) begin
                        w_next = C_ST_WB;
                    end
                end else begin
                    w_next = C_ST_WB;
                end
            end
            C_ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = w_store;
                if (mem_ready) begin
                    if (w_store) begin
                        pc_we    = 1'b1;
                        w_retire = 1'b1;
                        w_next   = C_ST_FETCH;
                    end else begin
                        w_next = C_ST_WB;
                    end
                end else if (w_timeout) begin
                    w_set_berr = 1'b1;
                    w_next     = C_ST_HALT;
                end
            end
            C_ST_WB: begin
                pc_we       = 1'b1;
                rd_we       = ~w_fp;
                frd_we      = w_fp;
                pc_next_sel = w_jal | w_jalr;
                pc_alu_sel  = w_jal | w_auipc;
                sub_sra     = w_sub;
                w_retire    = 1'b1;
                w_next      = C_ST_FETCH;
            end
            C_ST_HALT: begin
                w_next = C_ST_HALT;
            end
            default: begin
                w_next = C_ST_HALT;
            end
        endcase

        // Reset forces FETCH, whose Moore outputs must not leak while rst_n is low
        if (!rst_n) begin
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            addr_sel    = 1'b0;
            ir_we       = 1'b0;
            pc_we       = 1'b0;
            pc_next_sel = 1'b0;
            pc_alu_sel  = 1'b0;
            sub_sra     = 1'b0;
            rd_we       = 1'b0;
            frd_we      = 1'b0;
            fpu_start   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= C_ST_FETCH;
            r_to_cnt      <= '0;
            r_fpu_started <= 1'b0;
            r_halted      <= 1'b0;
            r_illegal     <= 1'b0;
            r_bus_err     <= 1'b0;
            r_instret     <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_to_cnt <= '0;
            end else if (mem_req && !mem_ready) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            r_fpu_started <= (w_next == C_ST_EXEC) && (fpu_start || r_fpu_started);
            if (w_set_halt) r_halted  <= 1'b1;
            if (w_set_ill)  r_illegal <= 1'b1;
            if (w_set_berr) r_bus_err <= 1'b1;
            if (w_retire)   r_instret <= r_instret + 1'b1;
        end
    end

    assign halted  = r_halted;
    assign illegal = r_illegal;
    assign bus_err = r_bus_err;
    assign instret = r_instret;

endmodule

`default_nettype wire

// File: doc/insn_sequencer_mc.md
Name: insn_sequencer_mc

Overview:
- Multi-cycle instruction sequencer for the RV64F core.
- Replaces clock-gated single-cycle strobes (register/memory clocks derived from clk) with registered enables driven by an FSM.
- Adds memory and FPU handshakes, a bus timeout, halt/illegal detection and a retired-instruction counter.
- Sits in Control_Unit between the one-hot class decoder (OPDecoder successor) and the datapath (PC, IR, register file, ALU, FPU, memory port).

Parameters:
- N_CLASS, 11, width of one-hot class code; bits 0..9 are integer classes, bit 10 is FP.
- MEM_TIMEOUT, 255, max cycles waiting on mem_ready before bus error; 0 disables the timeout.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- code  in  N_CLASS  one-hot instruction class, decoded from IR; valid from DECODE onward
- insn  in  32  current IR contents
- EQ  in  1  ALU compare: equal
- LS  in  1  ALU compare: signed less-than
- LU  in  1  ALU compare: unsigned less-than
- mem_ready  in  1  memory completes current request this cycle
- fpu_done  in  1  FPU result valid, one-cycle pulse
- mem_req  out  1  memory request
- mem_we  out  1  store request (valid with mem_req)
- addr_sel  out  1  0 = PC address, 1 = ALU address
- ir_we  out  1  IR load enable
- pc_we  out  1  PC update enable
- pc_next_sel  out  1  0 = PC+4, 1 = ALU target
- pc_alu_sel  out  1  ALU operand A: 0 = rs1, 1 = PC
- sub_sra  out  1  ALU subtract / arithmetic-shift select
- rd_we  out  1  integer register-file write enable
- frd_we  out  1  FP register-file write enable
- fpu_start  out  1  one-cycle FPU start pulse
- halted  out  1  sticky: SYSTEM instruction executed
- illegal  out  1  sticky: code not one-hot
- bus_err  out  1  sticky: memory timeout
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset: rst_n low asynchronously forces state FETCH, clears instret, timeout counter and all sticky flags. All outputs are 0 during reset.
- Class bit map, fixed:
  - 0 JAL, 1 JALR, 2 AUIPC, 3 LUI, 4 BRANCH
  - 5 R-ALU, 6 STORE, 7 I-ALU, 8 LOAD, 9 SYSTEM, 10 FP
- State FETCH:
  - Drive mem_req=1, addr_sel=0.
  - When mem_ready=1: ir_we=1 in that same cycle, go to DECODE.
- State DECODE (1 cycle):
  - If code is zero or has more than one bit set: go to HALT and set illegal.
  - Else if SYSTEM: go to HALT and set halted.
  - Else go to EXEC.
- State EXEC, by class:
  - JAL, JALR, AUIPC, LUI, R-ALU, I-ALU: go to WB.
  - LOAD, STORE: go to MEM.
  - BRANCH: pc_we=1; pc_next_sel=taken, pc_alu_sel=1; instret increments; go to FETCH.
  - FP: pulse fpu_start=1 on the first EXEC cycle only, then wait for fpu_done and go to WB.
- State MEM:
  - Drive mem_req=1, addr_sel=1, mem_we=STORE.
  - When mem_ready=1: LOAD goes to WB. STORE asserts pc_we=1, instret increments, go to FETCH.
- State WB (1 cycle):
  - pc_we=1; rd_we=1, or frd_we=1 when FP; instret increments; go to FETCH.
  - pc_next_sel=1 for JAL/JALR.
  - pc_alu_sel=1 for JAL/AUIPC in EXEC and WB.
- State HALT: absorbing. All enables are 0; only reset exits it.
- Branch taken, from insn[14:12]:
  - 000: EQ
  - 001: !EQ
  - 100: LS
  - 101: !LS
  - 110: LU
  - 111: !LU
  - 010/011: illegal, go to HALT with illegal set, no PC write.
- sub_sra:
  - R-ALU: insn[30].
  - I-ALU: insn[30] only when funct3=101, else 0.
  - BRANCH: 1.
  - Otherwise: 0.
- Timeout:
  - Counter clears on entry to FETCH and MEM; increments each cycle with mem_req=1 and mem_ready=0.
  - On reaching MEM_TIMEOUT: go to HALT with bus_err set, no ir_we/pc_we.
  - mem_ready on the same cycle as the limit wins.
- instret: increments exactly once per retired instruction and wraps modulo 2^CNT_W.
- fpu_done outside FP EXEC is ignored. mem_ready outside FETCH/MEM is ignored.
- Output timing: mem_req, addr_sel and mem_we are Moore (state only). ir_we and MEM-state pc_we are combinational on mem_ready.

Decomposition:
- Package seq_pkg holds:
  - the state enum (FETCH, DECODE, EXEC, MEM, WB, HALT)
  - class bit-index constants
  - funct3 branch constants
- Sub-module branch_cond (combinational): insn[14:12], EQ, LS, LU -> taken, bad_funct3.

Test Plan:
- ADD (code bit5, insn[30]=0), mem_ready held 1 -> FETCH, DECODE, EXEC, WB; rd_we high exactly in cycle 4; instret=1; sub_sra=0.
- BEQ with EQ=1, then BNE with EQ=1 -> first: pc_we=1 and pc_next_sel=1 in EXEC, rd_we never asserted; second: pc_next_sel=0; instret=2.
- LW with mem_ready low 3 cycles in MEM -> mem_req and addr_sel=1 held 4 cycles, mem_we=0, then WB with rd_we=1.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> bus_err=1 after 4 wait cycles; state HALT; ir_we never asserted; holds until rst_n.
- FP op (bit10), fpu_done after 6 cycles -> fpu_start high exactly 1 cycle, frd_we=1 once, rd_we=0.
- code=11'b00000000011 -> illegal=1 in HALT. Separately, rst_n low mid-MEM -> all outputs 0 immediately; FETCH resumes with instret=0.
